// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   XLEN        : width of the fields carried in the IF/ID entry
//   NOP_INSTR   : canonical NOP (addi x0,x0,0). Presented on reset and with
//                 every fault entry.
//   FS_*_ENC    : fixed state encodings. The enum literals are bound to these
//                 values so that the encoding stays stable for anything that
//                 decodes the raw state bits.
//   fetch_state_e : fetch FSM state
//   if_id_t     : payload of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] FS_IDLE_ENC  = 2'd0;
    localparam logic [1:0] FS_FETCH_ENC = 2'd1;
    localparam logic [1:0] FS_FAULT_ENC = 2'd2;

    typedef enum logic [1:0] {
        FS_IDLE  = FS_IDLE_ENC,
        FS_FETCH = FS_FETCH_ENC,
        FS_FAULT = FS_FAULT_ENC
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } if_id_t;

    // A fetch target is legal only when it is word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// Single-entry valid/ready pipeline register between fetch and decode.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   load     : capture d this edge (only honoured when can_load is high)
//   flush    : drop the held entry; wins over load and over a transfer
//   ready    : downstream accepts the held entry this cycle
//   d        : entry to capture
//   can_load : register is empty or being drained this cycle
//   valid    : register holds an entry
//   q        : held entry
// Precedence: flush > load > drain-on-transfer > hold. The payload is left
// untouched by flush and drain; only valid qualifies it.
// -----------------------------------------------------------------------------
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  logic   ready,
    input  if_id_t d,
    output logic   can_load,
    output logic   valid,
    output if_id_t q
);

    localparam if_id_t RESET_ENTRY = '{instr: NOP_INSTR, pc: '0, fault: 1'b0};

    logic   valid_reg;
    logic   valid_next;
    if_id_t data_reg;
    if_id_t data_next;

    assign can_load = !valid_reg || ready;

    always_comb begin
        valid_next = valid_reg;
        data_next  = data_reg;
        if (flush) begin
            valid_next = 1'b0;
        end else if (load && can_load) begin
            valid_next = 1'b1;
            data_next  = d;
        end else if (valid_reg && ready) begin
            // Entry consumed with nothing to replace it.
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= RESET_ENTRY;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
        end
    end

    assign valid = valid_reg;
    assign q     = data_reg;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the PC, drives the combinational instruction
// ROM and registers each fetched word into the IF/ID register (if_id_reg)
// with a valid/ready handshake toward decode. Redirects from execute have
// priority over everything and flush the IF/ID register.
//
// Parameters:
//   ADDR_WIDTH   : PC / ROM byte address width (<= XLEN)
//   DATA_WIDTH   : instruction width (<= XLEN)
//   RESET_VECTOR : PC loaded at reset
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_addr_o       : ROM byte address, straight from the PC register
//   imem_data_i       : ROM data, valid in the same cycle
//   redirect_valid_i  : taken branch / jump from execute
//   redirect_pc_i     : redirect target
//   if_valid_o        : IF/ID holds an instruction
//   if_ready_i        : decode accepts (transfer = if_valid_o && if_ready_i)
//   if_instr_o        : registered instruction
//   if_pc_o           : PC of if_instr_o
//   if_fault_o        : misaligned-fetch fault, qualified by if_valid_o
//
// Build option FETCH_PERF_CNT_EN adds two free-running 32-bit counters:
//   perf_fetched_o    : transfers that were not voided by a redirect
//   perf_stall_o      : cycles with if_valid_o && !if_ready_i
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic                  if_fault_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_stall_o
`endif
);

    fetch_state_e          state_reg;
    fetch_state_e          state_next;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] pc_next;
    // Set by a misaligned redirect; cleared once the single fault entry has
    // been placed in IF/ID. Without it, "fault entry not yet issued" and
    // "fault entry already consumed" both look like an empty register.
    logic                  fault_pending_reg;
    logic                  fault_pending_next;

    logic                  reg_load;
    logic                  reg_flush;
    logic                  reg_can_load;
    logic                  reg_valid;
    if_id_t                reg_d;
    if_id_t                reg_q;

    logic                  redirect_misaligned;

    assign redirect_misaligned = is_misaligned(redirect_pc_i[1:0]);

    // -------------------------------------------------------------------------
    // Next-state logic. A redirect overrides every state: the PC takes the
    // target and IF/ID is flushed, so a transfer in the same cycle is void.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        pc_next            = pc_reg;
        fault_pending_next = fault_pending_reg;
        reg_load           = 1'b0;
        reg_flush          = 1'b0;
        reg_d              = '{instr: XLEN'(imem_data_i), pc: XLEN'(pc_reg), fault: 1'b0};

        if (redirect_valid_i) begin
            reg_flush = 1'b1;
            pc_next   = redirect_pc_i;
            if (redirect_misaligned) begin
                state_next         = FS_FAULT;
                fault_pending_next = 1'b1;
            end else begin
                state_next         = FS_FETCH;
                fault_pending_next = 1'b0;
            end
        end else begin
            case (state_reg)
                FS_IDLE: begin
                    // Reset bubble: nothing is fetched on the first edge.
                    state_next = FS_FETCH;
                end
                FS_FETCH: begin
                    // When IF/ID is full and stalled, nothing moves: the PC
                    // holds and the ROM word is simply re-read next cycle.
                    if (reg_can_load) begin
                        reg_load = 1'b1;
                        pc_next  = pc_reg + ADDR_WIDTH'(4);
                    end
                end
                FS_FAULT: begin
                    // Issue exactly one fault entry carrying the bad target,
                    // then sit idle until execute redirects us elsewhere.
                    if (fault_pending_reg && reg_can_load) begin
                        reg_load           = 1'b1;
                        reg_d              = '{instr: NOP_INSTR, pc: XLEN'(pc_reg), fault: 1'b1};
                        fault_pending_next = 1'b0;
                    end
                end
                default: begin
                    state_next = FS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= FS_IDLE;
            pc_reg            <= RESET_VECTOR;
            fault_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            fault_pending_reg <= fault_pending_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (reg_load),
        .flush    (reg_flush),
        .ready    (if_ready_i),
        .d        (reg_d),
        .can_load (reg_can_load),
        .valid    (reg_valid),
        .q        (reg_q)
    );

    assign imem_addr_o = pc_reg;
    assign if_valid_o  = reg_valid;
    assign if_instr_o  = DATA_WIDTH'(reg_q.instr);
    assign if_pc_o     = ADDR_WIDTH'(reg_q.pc);
    assign if_fault_o  = reg_q.fault;

`ifdef FETCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters. Index 0 counts committed transfers (a transfer
    // coinciding with a redirect is void and not counted), index 1 counts
    // stall cycles. Both wrap naturally at 2^32.
    // -------------------------------------------------------------------------
    logic [1:0] perf_event;

    assign perf_event[0] = reg_valid && if_ready_i && !redirect_valid_i;
    assign perf_event[1] = reg_valid && !if_ready_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (perf_event[gi]) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetched_o = g_perf[0].cnt_reg;
    assign perf_stall_o   = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Directed scenarios cover reset, the
// fetch stream, backpressure, redirects, the misaligned-fault path, PC wrap
// and asynchronous reset. A randomized phase checks every committed transfer
// against a transaction-level model: after a redirect to T, decode must see
// T, T+4, T+8 ... (or one NOP fault entry at T when T is misaligned), and a
// stalled entry must never change.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    // ROM: word i holds 0x100 + i.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h100 + (addr >> 2);
    endfunction

    assign imem_data = rom_word(imem_addr);

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr_o      (imem_addr),
        .imem_data_i      (imem_data),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .if_valid_o       (if_valid),
        .if_ready_i       (if_ready),
        .if_instr_o       (if_instr),
        .if_pc_o          (if_pc),
        .if_fault_o       (if_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o   (perf_fetched),
        .perf_stall_o     (perf_stall)
`endif
    );

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n          = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({if_valid, if_instr, if_pc, if_fault, imem_addr} !== {1'b0, 32'h13, 32'h0, 1'b0, 32'h0})
            $display("FAIL reset_outputs: got v=%b instr=%h pc=%h f=%b addr=%h, want v=0 instr=00000013 pc=0 f=0 addr=0",
                     if_valid, if_instr, if_pc, if_fault, imem_addr);
        else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
        check_cnt++;
        if ({perf_fetched, perf_stall} !== 64'h0)
            $display("FAIL reset_perf: got fetched=%0d stall=%0d, want 0/0", perf_fetched, perf_stall);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_stream();
        tick();
        check_cnt++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h0})
            $display("FAIL stream_bubble: got v=%b addr=%h, want v=0 addr=0", if_valid, imem_addr);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cnt++;
            if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, 32'(4 * i), 32'(32'h100 + i), 1'b0})
                $display("FAIL stream_%0d: got v=%b pc=%h instr=%h f=%b, want v=1 pc=%h instr=%h f=0",
                         i, if_valid, if_pc, if_instr, if_fault, 32'(4 * i), 32'(32'h100 + i));
            else pass_cnt++;
            $display("stream pc=%h instr=%h", if_pc, if_instr);
        end
        check_cnt++;
        if (imem_addr !== 32'hC)
            $display("FAIL stream_addr: got %h want 0000000c", imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cnt++;
            if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h8, 32'h102, 32'hC})
                $display("FAIL bp_hold_%0d: got v=%b pc=%h instr=%h addr=%h, want v=1 pc=8 instr=102 addr=c",
                         i, if_valid, if_pc, if_instr, imem_addr);
            else pass_cnt++;
        end
        if_ready = 1'b1;
        tick();
        check_cnt++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hC, 32'h103})
            $display("FAIL bp_release: got v=%b pc=%h instr=%h, want v=1 pc=c instr=103", if_valid, if_pc, if_instr);
        else pass_cnt++;
        $display("backpressure released pc=%h", if_pc);
    endtask

    task automatic test_redirect();
        if_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        check_cnt++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h40})
            $display("FAIL redir_flush: got v=%b addr=%h, want v=0 addr=40", if_valid, imem_addr);
        else pass_cnt++;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        tick();
        check_cnt++;
        if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, 32'h40, 32'h110, 1'b0})
            $display("FAIL redir_target: got v=%b pc=%h instr=%h f=%b, want v=1 pc=40 instr=110 f=0",
                     if_valid, if_pc, if_instr, if_fault);
        else pass_cnt++;
        $display("redirect delivered pc=%h", if_pc);
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check_cnt++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h42})
            $display("FAIL fault_flush: got v=%b addr=%h, want v=0 addr=42", if_valid, imem_addr);
        else pass_cnt++;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_cnt++;
            if ({if_valid, if_fault, if_instr, if_pc} !== {1'b1, 1'b1, 32'h13, 32'h42})
                $display("FAIL fault_entry_%0d: got v=%b f=%b instr=%h pc=%h, want v=1 f=1 instr=13 pc=42",
                         i, if_valid, if_fault, if_instr, if_pc);
            else pass_cnt++;
        end
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_cnt++;
            if ({if_valid, imem_addr} !== {1'b0, 32'h42})
                $display("FAIL fault_quiet_%0d: got v=%b addr=%h, want v=0 addr=42", i, if_valid, imem_addr);
            else pass_cnt++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_cnt++;
        if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, 32'h80, 32'h120, 1'b0})
            $display("FAIL fault_resume: got v=%b pc=%h instr=%h f=%b, want v=1 pc=80 instr=120 f=0",
                     if_valid, if_pc, if_instr, if_fault);
        else pass_cnt++;
        $display("fault path resumed pc=%h", if_pc);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_cnt++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h4000_00FF, 32'h0})
            $display("FAIL wrap_top: got v=%b pc=%h instr=%h addr=%h, want v=1 pc=fffffffc instr=400000ff addr=0",
                     if_valid, if_pc, if_instr, imem_addr);
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h100})
            $display("FAIL wrap_zero: got v=%b pc=%h instr=%h, want v=1 pc=0 instr=100", if_valid, if_pc, if_instr);
        else pass_cnt++;
        check_cnt++;
        if ($isunknown({if_valid, if_pc, if_instr, if_fault, imem_addr}) !== 1'b0)
            $display("FAIL wrap_noX: got unknown bits on outputs, want none");
        else pass_cnt++;
        $display("wrap delivered pc=%h", if_pc);
    endtask

    task automatic test_random();
        logic [31:0] exp_pc     = 32'h0;
        logic [31:0] fault_pc   = 32'h0;
        logic        fault_mode = 1'b0;
        logic        fault_done = 1'b0;
        logic        prev_stall = 1'b0;
        logic [64:0] prev_snap  = '0;
        logic        r_ready;
        logic        r_redir;
        logic [31:0] r_pc;
        int          xfers      = 0;

        for (int i = 0; i < 400; i++) begin
            if (prev_stall) begin
                check_cnt++;
                if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, prev_snap})
                    $display("FAIL rnd_hold cyc %0d: got v=%b pc=%h instr=%h f=%b, want v=1 pc=%h instr=%h f=%b",
                             i, if_valid, if_pc, if_instr, if_fault, prev_snap[64:33], prev_snap[32:1], prev_snap[0]);
                else pass_cnt++;
            end
            if (fault_mode && fault_done) begin
                check_cnt++;
                if (if_valid !== 1'b0)
                    $display("FAIL rnd_fault_quiet cyc %0d: got v=%b want v=0", i, if_valid);
                else pass_cnt++;
            end

            r_ready = ($urandom_range(0, 9) < 7);
            r_redir = (i == 0) || ($urandom_range(0, 15) == 0);
            r_pc    = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) r_pc = 32'hFFFF_FFF0;
            if ($urandom_range(0, 3) == 0) r_pc = r_pc + 32'($urandom_range(1, 3));
            if (i == 0) r_pc = 32'h200;
            if_ready       = r_ready;
            redirect_valid = r_redir;
            redirect_pc    = r_pc;

            if (if_valid && r_ready && !r_redir) begin
                check_cnt++;
                if (fault_mode) begin
                    if ({if_fault, if_pc, if_instr, fault_done} !== {1'b1, fault_pc, 32'h13, 1'b0})
                        $display("FAIL rnd_fault_xfer cyc %0d: got f=%b pc=%h instr=%h, want f=1 pc=%h instr=13 (single entry)",
                                 i, if_fault, if_pc, if_instr, fault_pc);
                    else pass_cnt++;
                    fault_done = 1'b1;
                end else begin
                    if ({if_fault, if_pc, if_instr} !== {1'b0, exp_pc, rom_word(exp_pc)})
                        $display("FAIL rnd_xfer cyc %0d: got f=%b pc=%h instr=%h, want f=0 pc=%h instr=%h",
                                 i, if_fault, if_pc, if_instr, exp_pc, rom_word(exp_pc));
                    else pass_cnt++;
                    exp_pc = exp_pc + 32'd4;
                end
                xfers++;
                $display("xfer cyc %0d pc=%h instr=%h fault=%b", i, if_pc, if_instr, if_fault);
            end

            if (r_redir) begin
                exp_pc     = r_pc;
                fault_pc   = r_pc;
                fault_mode = (r_pc[1:0] != 2'b00);
                fault_done = 1'b0;
            end
            prev_stall = if_valid && !r_ready && !r_redir;
            prev_snap  = {if_pc, if_instr, if_fault};
            tick();
        end
        redirect_valid = 1'b0;
        check_cnt++;
        if (xfers < 40)
            $display("FAIL rnd_progress: got %0d transfers, want at least 40", xfers);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        // Reset from whatever state the random phase left, without an edge.
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({if_valid, if_instr, if_pc, if_fault, imem_addr} !== {1'b0, 32'h13, 32'h0, 1'b0, 32'h0})
            $display("FAIL areset_a: got v=%b instr=%h pc=%h f=%b addr=%h, want v=0 instr=13 pc=0 f=0 addr=0",
                     if_valid, if_instr, if_pc, if_fault, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        rst_n          = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            $display("perf xfer pc=%h", if_pc);
            tick();
        end
        if_ready = 1'b0;
        repeat (2) tick();
        check_cnt++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h14, 32'h105})
            $display("FAIL areset_stall: got v=%b pc=%h instr=%h, want v=1 pc=14 instr=105", if_valid, if_pc, if_instr);
        else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
        check_cnt++;
        if ({perf_fetched, perf_stall} !== {32'd5, 32'd2})
            $display("FAIL perf_counts: got fetched=%0d stall=%0d, want 5/2", perf_fetched, perf_stall);
        else pass_cnt++;
`endif
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({if_valid, if_instr, if_pc, if_fault, imem_addr} !== {1'b0, 32'h13, 32'h0, 1'b0, 32'h0})
            $display("FAIL areset_b: got v=%b instr=%h pc=%h f=%b addr=%h, want v=0 instr=13 pc=0 f=0 addr=0",
                     if_valid, if_instr, if_pc, if_fault, imem_addr);
        else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
        check_cnt++;
        if ({perf_fetched, perf_stall} !== 64'h0)
            $display("FAIL perf_clear: got fetched=%0d stall=%0d, want 0/0", perf_fetched, perf_stall);
        else pass_cnt++;
`endif
        $display("async reset mid-stall done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
